// File: rtl/apb_completer_regfile.sv
// apb_completer_regfile
//   APB3/APB4 completer holding a bank of 32-bit registers with a configurable
//   number of PREADY-low wait states. Register 0 is a read-only ID word; the
//   rest are byte-strobed read/write and clear on reset.
// Ports
//   PCLK, PRESET          : clock, synchronous active-high reset
//   PSEL, PENABLE, PWRITE : APB control
//   PADDR                 : byte address (word index = PADDR[2 +: clog2(NUM_REGS)])
//   PWDATA, PSTRB         : write data and byte strobes (sampled at commit)
//   PRDATA                : read data, valid while PREADY=1 on a read
//   PREADY, PSLVERR       : transfer complete / error response
module apb_completer_regfile #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [ADDR_WIDTH-1:0]     PADDR,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR
);

    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              wait_cnt;
    logic [IDX_W-1:0]        idx_q;
    logic                    write_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    // Address decode on the live bus; only used at the setup-capture edge.
    logic [IDX_W-1:0]        idx_in;
    logic                    upper_nz;
    logic                    err_in;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic                    setup;
    logic                    complete;

    assign idx_in = PADDR[2 +: IDX_W];

    generate
        if (ADDR_WIDTH > 2 + IDX_W) begin : g_upper
            assign upper_nz = |PADDR[ADDR_WIDTH-1:2+IDX_W];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    assign err_in = (|PADDR[1:0]) || upper_nz || (32'(idx_in) >= NUM_REGS)
                 || (PWRITE && (idx_in == '0));

    // Register 0 storage is never written; the ID word is muxed in here.
    assign rd_val = (idx_in == '0) ? DATA_WIDTH'(ID_VALUE) : regs[idx_in];

    assign setup    = (state == IDLE) && PSEL && !PENABLE;
    assign complete = (state == ACCESS) && PSEL && PENABLE && (wait_cnt == 3'd0);

    // FSM: state register
    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (setup) state_nxt = ACCESS;
            ACCESS: if (!PSEL || complete) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs, decoded from registers only
    always_comb begin
        PREADY  = (state == ACCESS) && (wait_cnt == 3'd0);
        PSLVERR = PREADY && err_q;
    end

    // Transfer context and read data
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_cnt <= 3'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            PRDATA   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        idx_q    <= idx_in;
                        write_q  <= PWRITE;
                        err_q    <= err_in;
                        wait_cnt <= 3'(WAIT_STATES);
                        PRDATA   <= (err_in || PWRITE) ? '0 : rd_val;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        wait_cnt <= 3'd0;
                        PRDATA   <= '0;
                    end else if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else if (PENABLE) begin
                        PRDATA   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register bank; err_q guarantees idx_q != 0 on a committed write
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (complete && write_q && !err_q) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (PSTRB[b]) regs[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb_completer_regfile.sv
`timescale 1ns/1ps
module tb_apb_completer_regfile;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel0, psel1, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        er;
    int          wt;

    always #5 pclk = ~pclk;

    // dut0: one wait state
    apb_completer_regfile #(.WAIT_STATES(1)) dut0 (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    // dut1: zero wait states
    apb_completer_regfile #(.WAIT_STATES(0)) dut1 (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel1), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One APB transfer; returns data/err sampled on the PREADY=1 cycle and the
    // number of PREADY-low access cycles. Ends just before the completing edge.
    task automatic xfer(input int which, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic err, output int waits);
        logic rdy;
        @(negedge pclk);
        psel0 = (which == 0); psel1 = (which == 1);
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        @(negedge pclk);
        penable = 1'b1;
        waits = 0;
        rdy = (which == 0) ? pready0 : pready1;
        while (!rdy && waits < 16) begin
            waits++;
            @(negedge pclk);
            rdy = (which == 0) ? pready0 : pready1;
        end
        if (!rdy) check("pready_timeout", {31'd0, rdy}, 32'd1);
        rdata = (which == 0) ? prdata0 : prdata1;
        err   = (which == 0) ? pslverr0 : pslverr1;
    endtask

    task automatic bus_idle();
        @(negedge pclk);
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        preset = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;

        // 1 reset
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("rst_pready",  {31'd0, pready0},  32'd0);
        check("rst_pslverr", {31'd0, pslverr0}, 32'd0);
        check("rst_prdata",  prdata0, 32'd0);
        preset = 1'b0;
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, wt);
        check("rd_id", rd, 32'hA9B0_0001);
        check("rd_id_err", {31'd0, er}, 32'd0);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, wt);
        check("rd4_rst", rd, 32'h0);

        // 2 one wait state write/read
        xfer(0, 1'b1, 32'h4, 32'h0000_ABCD, 4'hF, rd, er, wt);
        check("wr4_waits", wt, 32'd1);
        check("wr4_err", {31'd0, er}, 32'd0);
        check("wr4_prdata", rd, 32'h0);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, wt);
        check("rd4", rd, 32'h0000_ABCD);
        check("rd4_waits", wt, 32'd1);
        @(negedge pclk);
        check("prdata_idle", prdata0, 32'h0);

        // 3 strobes, including an all-zero strobe no-op
        xfer(0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF, rd, er, wt);
        xfer(0, 1'b1, 32'h8, 32'h1234_5678, 4'b0101, rd, er, wt);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, wt);
        check("rd8_strb", rd, 32'hFF34_FF78);
        xfer(0, 1'b1, 32'h8, 32'h0, 4'b0000, rd, er, wt);
        check("strb0_err", {31'd0, er}, 32'd0);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, wt);
        check("rd8_strb0", rd, 32'hFF34_FF78);

        // 4 errors
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, wt);
        check("err40", {31'd0, er}, 32'd1);
        check("err40_data", rd, 32'h0);
        xfer(0, 1'b0, 32'h5, 32'h0, 4'h0, rd, er, wt);
        check("err5", {31'd0, er}, 32'd1);
        check("err5_data", rd, 32'h0);
        xfer(0, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, rd, er, wt);
        check("err_wr0", {31'd0, er}, 32'd1);
        check("err_wr0_data", rd, 32'h0);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, wt);
        check("id_kept", rd, 32'hA9B0_0001);
        check("id_kept_err", {31'd0, er}, 32'd0);

        // 5a abort during the wait state of a write to 0xC
        @(negedge pclk);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC;
        pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        @(negedge pclk);
        check("abort_wait", {31'd0, pready0}, 32'd0);
        psel0 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("abort_pready", {31'd0, pready0}, 32'd0);
        xfer(0, 1'b0, 32'hC, 32'h0, 4'h0, rd, er, wt);
        check("abort_nowr", rd, 32'h0);

        // 5b reset mid-access
        xfer(0, 1'b1, 32'hC, 32'h0BAD_F00D, 4'hF, rd, er, wt);
        @(negedge pclk);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8;
        pwdata = 32'h1111_1111; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1; preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0; psel0 = 1'b0; penable = 1'b0;
        check("rstmid_pready",  {31'd0, pready0},  32'd0);
        check("rstmid_pslverr", {31'd0, pslverr0}, 32'd0);
        check("rstmid_prdata",  prdata0, 32'h0);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, wt);
        check("rstmid_r4", rd, 32'h0);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, wt);
        check("rstmid_r8", rd, 32'h0);
        xfer(0, 1'b0, 32'hC, 32'h0, 4'h0, rd, er, wt);
        check("rstmid_rC", rd, 32'h0);
        bus_idle();

        // 6 zero wait states, back-to-back write then read
        xfer(1, 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, rd, er, wt);
        check("zw_wr_waits", wt, 32'd0);
        check("zw_wr_err", {31'd0, er}, 32'd0);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, wt);
        check("zw_rd_waits", wt, 32'd0);
        check("zw_rd", rd, 32'hCAFE_F00D);
        xfer(1, 1'b0, 32'h3, 32'h0, 4'h0, rd, er, wt);
        check("zw_err", {31'd0, er}, 32'd1);
        check("zw_err_data", rd, 32'h0);
        bus_idle();
        @(negedge pclk);
        check("zw_idle_pslverr", {31'd0, pslverr1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
